// File: rtl/lcv_mul_acc_sched.sv
// lcv_mul_acc_sched: round-robin scheduler sharing one pipelined signed MAC among NUM_REQ requesters.
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot or zero)
//   req_a/req_b/req_c   : packed per-requester operands; req_acc selects the running accumulator as addend
//   rsp_valid/rsp_data  : per-requester result pulse and held result
//   mac_a..mac_e        : registered operands to the external MAC; mac_outp returns MAC_LAT cycles later
module lcv_mul_acc_sched #(
    parameter int NUM_REQ = 4,
    parameter int MAC_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    input  logic [33*NUM_REQ-1:0]  req_c,
    input  logic [NUM_REQ-1:0]     req_acc,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [33*NUM_REQ-1:0]  rsp_data,
    output logic [15:0]            mac_a,
    output logic [15:0]            mac_b,
    output logic [32:0]            mac_c,
    output logic [32:0]            mac_d,
    output logic [32:0]            mac_e,
    input  logic [32:0]            mac_outp
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int NS = MAC_LAT + 1;

    logic [NUM_REQ-1:0]    busy_q, busy_d, rsp_valid_q, rsp_valid_d, gnt;
    logic [IW-1:0]         rr_q, rr_d, gidx, widx, idx;
    logic                  found;
    logic [32:0]           acc_q [NUM_REQ];
    logic [32:0]           acc_d [NUM_REQ];
    logic [33*NUM_REQ-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]           mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [32:0]           mac_c_q, mac_c_d;
    logic [NS-1:0]         tag_v_q, tag_v_d;
    logic [IW-1:0]         tag_id_q [NS];
    logic [IW-1:0]         tag_id_d [NS];

    // first eligible requester scanning upward from rr_q
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx] && !busy_q[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        gnt = found ? (NUM_REQ'(1) << gidx) : '0;
    end

    always_comb begin
        busy_d      = busy_q;
        rr_d        = rr_q;
        acc_d       = acc_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = '0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_c_d     = mac_c_q;
        widx        = tag_id_q[NS-1];
        tag_v_d     = {tag_v_q[NS-2:0], found};
        tag_id_d[0] = gidx;
        for (int s = 1; s < NS; s++)
            tag_id_d[s] = tag_id_q[s-1];
        // result retire; busy blocks a same-requester grant, so this never collides with the issue below
        if (tag_v_q[NS-1]) begin
            acc_d[widx]               = mac_outp;
            rsp_data_d[33*widx +: 33] = mac_outp;
            rsp_valid_d[widx]         = 1'b1;
            busy_d[widx]              = 1'b0;
        end
        if (found) begin
            busy_d[gidx] = 1'b1;
            rr_d         = IW'((int'(gidx) + 1) % NUM_REQ);
            mac_a_d      = req_a[16*gidx +: 16];
            mac_b_d      = req_b[16*gidx +: 16];
            mac_c_d      = req_acc[gidx] ? acc_q[gidx] : req_c[33*gidx +: 33];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            rr_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                acc_q[i] <= '0;
            for (int s = 0; s < NS; s++)
                tag_id_q[s] <= '0;
        end else begin
            busy_q      <= busy_d;
            rr_q        <= rr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_c_q     <= mac_c_d;
            tag_v_q     <= tag_v_d;
            acc_q       <= acc_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign req_ready = rst ? '0 : gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_c     = mac_c_q;
    assign mac_d     = '0;
    assign mac_e     = '0;
endmodule
